// File: rtl/ta_pkg.sv
// Shared types and defaults for the ta capture sequencer slice.
package ta_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MRST,
        S_TRIG,
        S_WAITR,
        S_WIN,
        S_GAP,
        S_DONE
    } ta_state_e;

    localparam int unsigned MRST_DEFAULT = 8;
    localparam int unsigned CNT_DEFAULT  = 16;

endpackage

// File: rtl/ta_dncnt.sv
// Loadable down-counter with a zero flag; load takes priority over decrement.
module ta_dncnt #(
    parameter int unsigned CNT0_0 = 16
) (
    input  logic              clk250,
    input  logic              rst,
    input  logic              load,
    input  logic [CNT0_0-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [CNT0_0-1:0] count;

    always_ff @(posedge clk250) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - CNT0_0'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ta_cap_seq.sv
// Capture sequencer: memory reset, then per shot trigger / wait-ready / merge window / gap.
module ta_cap_seq
    import ta_pkg::*;
#(
    parameter int unsigned CNT0_0  = CNT_DEFAULT,
    parameter int unsigned MRST0_0 = MRST_DEFAULT
) (
    input  logic              clk250,
    input  logic              rst,
    input  logic              seq_start,
    input  logic              seq_abort,
    input  logic [CNT0_0-1:0] shot_num,
    input  logic [CNT0_0-1:0] win_len,
    input  logic [CNT0_0-1:0] gap_len,
    input  logic [CNT0_0-1:0] rdy_tmo,
    input  logic              lddr_rdy,
    output logic              mem_reset,
    output logic              ldd_trig,
    output logic              merge_en,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [CNT0_0-1:0] shot_cnt
);

    ta_state_e         state, state_nxt;
    logic [CNT0_0-1:0] shot_num_q, win_len_q, gap_len_q, rdy_tmo_q;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT0_0-1:0] cnt_val;
    logic              start_acc, tmo_hit, win_end;
    logic              last_shot;

    ta_dncnt #(.CNT0_0(CNT0_0)) u_cnt (
        .clk250   (clk250),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign last_shot = ((shot_cnt + CNT0_0'(1)) == shot_num_q);

    // Counter is loaded with (length - 1) on entry so a phase lasts exactly length cycles.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        start_acc = 1'b0;
        tmo_hit   = 1'b0;
        win_end   = 1'b0;
        if (state != S_IDLE && seq_abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (seq_start && !seq_abort) begin
                        start_acc = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = CNT0_0'(MRST0_0 - 1);
                        state_nxt = (shot_num == '0) ? S_DONE : S_MRST;
                    end
                end
                S_MRST: begin
                    if (cnt_zero) state_nxt = S_TRIG;
                    else          cnt_dec   = 1'b1;
                end
                S_TRIG: begin
                    state_nxt = S_WAITR;
                    cnt_load  = 1'b1;
                    cnt_val   = rdy_tmo_q - CNT0_0'(1);
                end
                S_WAITR: begin
                    if (lddr_rdy) begin
                        state_nxt = S_WIN;
                        cnt_load  = 1'b1;
                        cnt_val   = (win_len_q == '0) ? '0 : win_len_q - CNT0_0'(1);
                    end else if (rdy_tmo_q != '0 && cnt_zero) begin
                        state_nxt = S_DONE;
                        tmo_hit   = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_WIN: begin
                    if (cnt_zero) begin
                        win_end = 1'b1;
                        if (last_shot) begin
                            state_nxt = S_DONE;
                        end else if (gap_len_q == '0) begin
                            state_nxt = S_TRIG;
                        end else begin
                            state_nxt = S_GAP;
                            cnt_load  = 1'b1;
                            cnt_val   = gap_len_q - CNT0_0'(1);
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_zero) state_nxt = S_TRIG;
                    else          cnt_dec   = 1'b1;
                end
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk250) begin
        if (rst) begin
            state      <= S_IDLE;
            shot_num_q <= '0;
            win_len_q  <= '0;
            gap_len_q  <= '0;
            rdy_tmo_q  <= '0;
            shot_cnt   <= '0;
            seq_err    <= 1'b0;
            mem_reset  <= 1'b0;
            ldd_trig   <= 1'b0;
            merge_en   <= 1'b0;
            seq_busy   <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_reset <= (state_nxt == S_MRST);
            ldd_trig  <= (state_nxt == S_TRIG);
            merge_en  <= (state_nxt == S_WIN);
            seq_busy  <= (state_nxt != S_IDLE);
            seq_done  <= (state_nxt == S_DONE);
            if (start_acc) begin
                shot_num_q <= shot_num;
                win_len_q  <= win_len;
                gap_len_q  <= gap_len;
                rdy_tmo_q  <= rdy_tmo;
                shot_cnt   <= '0;
                seq_err    <= 1'b0;
            end else begin
                if (win_end && shot_cnt != shot_num_q) shot_cnt <= shot_cnt + CNT0_0'(1);
                if (tmo_hit) seq_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ta_cap_seq.sv
// Directed bench for ta_cap_seq with hand-computed cycle positions relative to the start edge.
module tb_ta_cap_seq;

    logic        clk250 = 1'b0;
    logic        rst;
    logic        seq_start, seq_abort, lddr_rdy;
    logic [15:0] shot_num, win_len, gap_len, rdy_tmo;
    logic        mem_reset, ldd_trig, merge_en, seq_busy, seq_done, seq_err;
    logic [15:0] shot_cnt;

    int checks = 0;
    int errors = 0;

    // Observation record filled by observe(); k = 1 is the sample after the start edge.
    int n_mrst, mrst_first, mrst_last;
    int trig_n, trig_k0, trig_k1, trig_k2;
    int merge_n, merge_bursts, merge_first;
    int done_k, err_at_done, cnt_at_done;

    always #2 clk250 = ~clk250;

    ta_cap_seq #(.CNT0_0(16), .MRST0_0(8)) dut (
        .clk250    (clk250),
        .rst       (rst),
        .seq_start (seq_start),
        .seq_abort (seq_abort),
        .shot_num  (shot_num),
        .win_len   (win_len),
        .gap_len   (gap_len),
        .rdy_tmo   (rdy_tmo),
        .lddr_rdy  (lddr_rdy),
        .mem_reset (mem_reset),
        .ldd_trig  (ldd_trig),
        .merge_en  (merge_en),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .seq_err   (seq_err),
        .shot_cnt  (shot_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input int sn, input int wl, input int gl, input int tmo);
        shot_num  = 16'(sn);
        win_len   = 16'(wl);
        gap_len   = 16'(gl);
        rdy_tmo   = 16'(tmo);
        seq_start = 1'b1;
    endtask

    // Steps until seq_done (or maxc cycles); at poke_k it re-pulses seq_start with a new shot_num.
    task automatic observe(input int maxc, input int poke_k);
        logic prev_m;
        n_mrst = 0; mrst_first = 0; mrst_last = 0;
        trig_n = 0; trig_k0 = 0; trig_k1 = 0; trig_k2 = 0;
        merge_n = 0; merge_bursts = 0; merge_first = 0;
        done_k = 0; err_at_done = 0; cnt_at_done = 0;
        prev_m = 1'b0;
        for (int k = 1; k <= maxc && done_k == 0; k++) begin
            @(negedge clk250);
            seq_start = 1'b0;
            if (k == poke_k) begin
                seq_start = 1'b1;
                shot_num  = 16'd5;
            end
            if (mem_reset) begin
                n_mrst++;
                if (mrst_first == 0) mrst_first = k;
                mrst_last = k;
            end
            if (ldd_trig) begin
                if (trig_n == 0) trig_k0 = k;
                if (trig_n == 1) trig_k1 = k;
                if (trig_n == 2) trig_k2 = k;
                trig_n++;
            end
            if (merge_en) begin
                merge_n++;
                if (!prev_m) merge_bursts++;
                if (merge_first == 0) merge_first = k;
            end
            prev_m = merge_en;
            if (seq_done) begin
                done_k      = k;
                err_at_done = int'(seq_err);
                cnt_at_done = int'(shot_cnt);
            end
        end
        seq_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; seq_start = 1'b0; seq_abort = 1'b0; lddr_rdy = 1'b1;
        shot_num = '0; win_len = '0; gap_len = '0; rdy_tmo = '0;
        repeat (3) @(negedge clk250);
        chk("rst_busy", 32'(seq_busy), 0);
        chk("rst_outs", {26'd0, mem_reset, ldd_trig, merge_en, seq_done, seq_err, 1'b0}, 0);
        chk("rst_shot_cnt", 32'(shot_cnt), 0);
        rst = 1'b0;
        @(negedge clk250);

        // Basic burst: 3 shots, W=4, gap 2 -> trig at 9,17,25; done at 31.
        start_burst(3, 4, 2, 0);
        observe(200, 0);
        chk("basic_mrst_n", 32'(n_mrst), 8);
        chk("basic_mrst_first", 32'(mrst_first), 1);
        chk("basic_mrst_last", 32'(mrst_last), 8);
        chk("basic_trig_n", 32'(trig_n), 3);
        chk("basic_trig0", 32'(trig_k0), 9);
        chk("basic_trig1", 32'(trig_k1), 17);
        chk("basic_trig2", 32'(trig_k2), 25);
        chk("basic_merge_n", 32'(merge_n), 12);
        chk("basic_merge_bursts", 32'(merge_bursts), 3);
        chk("basic_merge_first", 32'(merge_first), 11);
        chk("basic_done_k", 32'(done_k), 31);
        chk("basic_cnt", 32'(cnt_at_done), 3);
        chk("basic_err", 32'(err_at_done), 0);
        @(negedge clk250);
        chk("basic_busy_fall", 32'(seq_busy), 0);
        chk("basic_cnt_hold", 32'(shot_cnt), 3);

        // Timeout: ready never returns.
        lddr_rdy = 1'b0;
        start_burst(2, 3, 0, 10);
        observe(200, 0);
        chk("tmo_done_seen", 32'(done_k != 0), 1);
        chk("tmo_err", 32'(err_at_done), 1);
        chk("tmo_cnt", 32'(cnt_at_done), 0);
        chk("tmo_merge_n", 32'(merge_n), 0);
        chk("tmo_trig_n", 32'(trig_n), 1);
        @(negedge clk250);
        chk("tmo_err_sticky", 32'(seq_err), 1);
        chk("tmo_idle", 32'(seq_busy), 0);

        // Abort at window cycle 2 of shot 2 (shot 2 window spans k=19..22).
        lddr_rdy = 1'b1;
        start_burst(3, 4, 2, 0);
        @(negedge clk250);
        seq_start = 1'b0;
        chk("abort_err_cleared", 32'(seq_err), 0);
        repeat (19) @(negedge clk250);
        chk("abort_in_window", 32'(merge_en), 1);
        seq_abort = 1'b1;
        @(negedge clk250);
        seq_abort = 1'b0;
        chk("abort_merge_drop", 32'(merge_en), 0);
        chk("abort_busy", 32'(seq_busy), 0);
        chk("abort_no_done", 32'(seq_done), 0);
        chk("abort_cnt", 32'(shot_cnt), 1);
        begin
            int dn;
            dn = 0;
            repeat (10) begin
                @(negedge clk250);
                if (seq_done || seq_busy) dn++;
            end
            chk("abort_stays_idle", 32'(dn), 0);
        end
        start_burst(1, 2, 0, 0);
        observe(200, 0);
        chk("abort_restart_done", 32'(done_k), 13);
        chk("abort_restart_cnt", 32'(cnt_at_done), 1);
        @(negedge clk250);

        // shot_num = 0: only a done pulse.
        start_burst(0, 4, 2, 0);
        observe(50, 0);
        chk("zero_done_k", 32'(done_k), 1);
        chk("zero_mrst_n", 32'(n_mrst), 0);
        chk("zero_trig_n", 32'(trig_n), 0);
        chk("zero_cnt", 32'(cnt_at_done), 0);
        @(negedge clk250);

        // win_len = 0 and gap_len = 0: 1-cycle windows, period 3.
        start_burst(2, 0, 0, 0);
        observe(200, 0);
        chk("w0_trig0", 32'(trig_k0), 9);
        chk("w0_trig1", 32'(trig_k1), 12);
        chk("w0_merge_n", 32'(merge_n), 2);
        chk("w0_merge_bursts", 32'(merge_bursts), 2);
        chk("w0_done_k", 32'(done_k), 15);
        chk("w0_cnt", 32'(cnt_at_done), 2);
        @(negedge clk250);

        // Mid-burst start and shot_num change are ignored.
        start_burst(2, 2, 1, 0);
        observe(200, 5);
        chk("relatch_trig_n", 32'(trig_n), 2);
        chk("relatch_trig1", 32'(trig_k1), 14);
        chk("relatch_done_k", 32'(done_k), 18);
        chk("relatch_cnt", 32'(cnt_at_done), 2);
        @(negedge clk250);

        // Start with abort in IDLE is refused.
        start_burst(2, 2, 1, 0);
        seq_abort = 1'b1;
        @(negedge clk250);
        seq_start = 1'b0;
        seq_abort = 1'b0;
        chk("startabort_busy", 32'(seq_busy), 0);
        chk("startabort_mrst", 32'(mem_reset), 0);
        @(negedge clk250);
        chk("startabort_busy2", 32'(seq_busy), 0);

        // Reset while stuck in WAITR of shot 2.
        start_burst(3, 4, 2, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk250);
            seq_start = 1'b0;
            if (k == 14) lddr_rdy = 1'b0;
        end
        chk("rstmid_busy_pre", 32'(seq_busy), 1);
        chk("rstmid_cnt_pre", 32'(shot_cnt), 1);
        rst = 1'b1;
        @(negedge clk250);
        rst = 1'b0;
        chk("rstmid_busy", 32'(seq_busy), 0);
        chk("rstmid_outs", {27'd0, mem_reset, ldd_trig, merge_en, seq_done, seq_err}, 0);
        chk("rstmid_cnt", 32'(shot_cnt), 0);
        lddr_rdy = 1'b1;
        @(negedge clk250);
        start_burst(1, 3, 0, 0);
        observe(200, 0);
        chk("rstmid_after_trig0", 32'(trig_k0), 9);
        chk("rstmid_after_done", 32'(done_k), 14);
        chk("rstmid_after_cnt", 32'(cnt_at_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
